// File: rtl/vga_pkg.sv
// Shared display types and helpers: RGB565/RGB888 pixel structs, 565->888 colour
// expansion and the colour-bar palette used by the test-pattern mode.
package vga_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    localparam rgb888_t BAR_WHITE   = 24'hFF_FF_FF;
    localparam rgb888_t BAR_YELLOW  = 24'hFF_FF_00;
    localparam rgb888_t BAR_CYAN    = 24'h00_FF_FF;
    localparam rgb888_t BAR_GREEN   = 24'h00_FF_00;
    localparam rgb888_t BAR_MAGENTA = 24'hFF_00_FF;
    localparam rgb888_t BAR_RED     = 24'hFF_00_00;
    localparam rgb888_t BAR_BLUE    = 24'h00_00_FF;
    localparam rgb888_t BAR_BLACK   = 24'h00_00_00;

    // Replicate the MSBs into the new LSBs so full-scale 565 maps to 0xFF.
    function automatic rgb888_t rgb565_to_888(input rgb565_t px);
        rgb888_t c;
        c.r = {px.r, px.r[4:2]};
        c.g = {px.g, px.g[5:4]};
        c.b = {px.b, px.b[4:2]};
        return c;
    endfunction

    // Bar colour by index, left to right across the active area.
    function automatic rgb888_t bar_colour(input logic [2:0] idx);
        rgb888_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_cnt.sv
// Raster timing core: horizontal/vertical counters, sync generation, active-area
// flag and frame-start strobe. Combinational flags describe the current counter
// state; sync/DE/frame_start outputs are registered one cycle later.
module vga_timing_cnt #(
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 192,
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 64,
    parameter int unsigned V_SYNC   = 7,
    parameter int unsigned V_BP     = 20,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic active_o,
    output logic frame_first_o,
    output logic hsync_o,
    output logic vsync_o,
    output logic de_o,
    output logic frame_start_o
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [31:0]   h_x, v_x;
    logic          hs_act, vs_act, h_act, v_act;
    logic          hsync_q, vsync_q, de_q, frame_start_q;

    // Compare in 32 bits so the parameter arithmetic needs no width juggling.
    assign h_x = 32'(h_q);
    assign v_x = 32'(v_q);

    assign hs_act        = (h_x < H_SYNC);
    assign vs_act        = (v_x < V_SYNC);
    assign h_act         = (h_x >= H_SYNC + H_BP) && (h_x < H_SYNC + H_BP + H_ACTIVE);
    assign v_act         = (v_x >= V_SYNC + V_BP) && (v_x < V_SYNC + V_BP + V_ACTIVE);
    assign active_o      = h_act && v_act;
    assign frame_first_o = (h_q == '0) && (v_q == '0);

    // Next raster position: h wraps each line, v advances on the h wrap.
    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end
    end

    // Counter state and registered timing outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hs_act ? HS_POL : ~HS_POL;
            vsync_q       <= vs_act ? VS_POL : ~VS_POL;
            de_q          <= active_o;
            frame_start_q <= frame_first_o;
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: rtl/vga_disp_gen.sv
// VGA/DVI timing generator with read-ahead RGB565 unpacker fed from an FWFT FIFO.
// Optional colour-bar test pattern is built when VGA_DISP_GEN_PATTERN_EN is defined
// (adds the pattern_sel input).
module vga_disp_gen
    import vga_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 192,
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 64,
    parameter int unsigned V_SYNC   = 7,
    parameter int unsigned V_BP     = 20,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic              vga_clk,
    input  logic              vga_rst_n,
    input  logic              ddr_init_done,
`ifdef VGA_DISP_GEN_PATTERN_EN
    input  logic              pattern_sel,
`endif
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    output logic              pix_rden,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_de,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              frame_start,
    output logic              underflow
);

    localparam int unsigned PPW     = DATA_W / 16;
    localparam int unsigned PH_W    = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PPW - 1);

    logic              active, frame_first;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic              frame_en_q, frame_en_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              word_ok_q, word_ok_d;
    logic              underflow_q, underflow_d;
    rgb888_t           colour_q, colour_d;
    logic              pattern_frame;
    logic              fetch_slot;
    logic [15:0]       cur_px;
    logic              px_ok;

    vga_timing_cnt #(
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL)
    ) u_timing (
        .clk_i         (vga_clk),
        .rst_ni        (vga_rst_n),
        .active_o      (active),
        .frame_first_o (frame_first),
        .hsync_o       (vga_hsync),
        .vsync_o       (vga_vsync),
        .de_o          (vga_de),
        .frame_start_o (frame_start)
    );

`ifdef VGA_DISP_GEN_PATTERN_EN
    localparam int unsigned COL_W = $clog2(H_ACTIVE);
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic             pattern_q, pattern_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [2:0]       bar_idx;

    assign pattern_frame = pattern_q;
    assign bar_idx       = 3'(32'(col_q) / BAR_W);

    // Pattern mode is latched per frame; column counts across the active line.
    always_comb begin
        pattern_d = frame_first ? pattern_sel : pattern_q;
        col_d     = active ? col_q + COL_W'(1) : '0;
    end

    // Pattern-mode state.
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            pattern_q <= 1'b0;
            col_q     <= '0;
        end else begin
            pattern_q <= pattern_d;
            col_q     <= col_d;
        end
    end
`else
    assign pattern_frame = 1'b0;
`endif

    // A word is due at the first pixel of each PPW group when the frame is live.
    assign fetch_slot = active && (ph_q == '0) && frame_en_q && !pattern_frame;
    assign pix_rden   = fetch_slot && pix_valid;

    // Pixel 0 comes straight off the FIFO head; later pixels from the shift register.
    assign cur_px = (ph_q == '0) ? pix_data[DATA_W-1 -: 16] : word_q[DATA_W-1 -: 16];
    assign px_ok  = (ph_q == '0) ? pix_valid : word_ok_q;

    // Phase, frame enable, shift register and underflow next-state.
    always_comb begin
        ph_d        = '0;
        frame_en_d  = frame_first ? ddr_init_done : frame_en_q;
        word_d      = word_q;
        word_ok_d   = word_ok_q;
        underflow_d = underflow_q;
        if (active && (ph_q != PH_LAST)) begin
            ph_d = ph_q + PH_W'(1);
        end
        if (pix_rden) begin
            // Pre-shift so the next phase finds its pixel in the top slot.
            word_d    = pix_data << 16;
            word_ok_d = 1'b1;
        end else if (fetch_slot) begin
            word_ok_d   = 1'b0;
            underflow_d = 1'b1;
        end else if (active && (ph_q != '0)) begin
            word_d = word_q << 16;
        end
    end

    // Output colour for the current counter state; black in blanking.
    always_comb begin
        colour_d = '0;
        if (active) begin
`ifdef VGA_DISP_GEN_PATTERN_EN
            if (pattern_frame) begin
                colour_d = bar_colour(bar_idx);
            end else if (frame_en_q && px_ok) begin
                colour_d = rgb565_to_888(rgb565_t'(cur_px));
            end
`else
            if (frame_en_q && px_ok) begin
                colour_d = rgb565_to_888(rgb565_t'(cur_px));
            end
`endif
        end
    end

    // Fetch/unpack state and registered colour outputs.
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            ph_q        <= '0;
            frame_en_q  <= 1'b0;
            word_q      <= '0;
            word_ok_q   <= 1'b0;
            underflow_q <= 1'b0;
            colour_q    <= '0;
        end else begin
            ph_q        <= ph_d;
            frame_en_q  <= frame_en_d;
            word_q      <= word_d;
            word_ok_q   <= word_ok_d;
            underflow_q <= underflow_d;
            colour_q    <= colour_d;
        end
    end

    assign vga_r     = colour_q.r;
    assign vga_g     = colour_q.g;
    assign vga_b     = colour_q.b;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_disp_gen.sv
// Self-checking bench for vga_disp_gen: small-timing instance checked cycle by cycle
// against a raster/FIFO reference model, plus a default-parameter instance for
// full-size sync timing.
module tb_vga_disp_gen;

    localparam int HT = 20;
    localparam int VT = 10;
    localparam int FT = HT * VT;
    localparam int DEF_HT = 1664;
    localparam logic [63:0] W = 64'hF800_07E0_001F_FFFF;

    logic        vga_clk = 1'b0;
    logic        vga_rst_n = 1'b0;
    logic        ddr_init_done = 1'b1;
    logic [63:0] pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        pix_rden, hs, vs, de, fs, uf;
    logic [7:0]  r, g, b;

    logic        d_ddr = 1'b0;
    logic [63:0] d_data = '0;
    logic        d_valid = 1'b0;
    logic        d_rden, d_hs, d_vs, d_de, d_fs, d_uf;
    logic [7:0]  d_r, d_g, d_b;

`ifdef VGA_DISP_GEN_PATTERN_EN
    logic pattern_sel = 1'b0;
`endif

    always #5 vga_clk = ~vga_clk;

    vga_disp_gen #(
        .DATA_W(64), .H_SYNC(4), .H_BP(4), .H_ACTIVE(8), .H_FP(4),
        .V_SYNC(2), .V_BP(2), .V_ACTIVE(4), .V_FP(2), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .vga_clk       (vga_clk),
        .vga_rst_n     (vga_rst_n),
        .ddr_init_done (ddr_init_done),
`ifdef VGA_DISP_GEN_PATTERN_EN
        .pattern_sel   (pattern_sel),
`endif
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_rden      (pix_rden),
        .vga_hsync     (hs),
        .vga_vsync     (vs),
        .vga_de        (de),
        .vga_r         (r),
        .vga_g         (g),
        .vga_b         (b),
        .frame_start   (fs),
        .underflow     (uf)
    );

    vga_disp_gen dut_def (
        .vga_clk       (vga_clk),
        .vga_rst_n     (vga_rst_n),
        .ddr_init_done (d_ddr),
`ifdef VGA_DISP_GEN_PATTERN_EN
        .pattern_sel   (pattern_sel),
`endif
        .pix_data      (d_data),
        .pix_valid     (d_valid),
        .pix_rden      (d_rden),
        .vga_hsync     (d_hs),
        .vga_vsync     (d_vs),
        .vga_de        (d_de),
        .vga_r         (d_r),
        .vga_g         (d_g),
        .vga_b         (d_b),
        .frame_start   (d_fs),
        .underflow     (d_uf)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int          t;
    bit          mfen, mok, mund;
    logic [63:0] mword;
    logic [63:0] fifo[$];
    int          mpops, obs_pops, de_cnt, nz_cnt;
    int          starve_line = -1;
    bit          rand_gate = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp888(input logic [15:0] p);
        int r5, g6, b5;
        r5 = int'(p[15:11]);
        g6 = int'(p[10:5]);
        b5 = int'(p[4:0]);
        return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
    endfunction

    task automatic fill(input bit rnd);
        while (fifo.size() < 24) fifo.push_back(rnd ? {$urandom, $urandom} : W);
    endtask

    task automatic model_reset();
        t = 0;
        mfen = 1'b0;
        mok = 1'b0;
        mund = 1'b0;
    endtask

    task automatic clear_counts();
        obs_pops = 0;
        mpops = 0;
        de_cnt = 0;
        nz_cnt = 0;
    endtask

    // One display clock: entered and left at posedge+1.
    task automatic step();
        int h, v, k;
        bit act, fs_e, fetch, valid_now, gate, ddr_s;
        logic [15:0] px;
        h = t % HT;
        v = (t / HT) % VT;
        act = (h >= 8) && (h < 16) && (v >= 4) && (v < 8);
        k = act ? (h - 8) % 4 : 0;
        fs_e = (h == 0) && (v == 0);
        gate = !((v == starve_line) && (h == 8));
        if (rand_gate && ($urandom_range(0, 3) == 0)) gate = 1'b0;
        valid_now = gate && (fifo.size() > 0);
        pix_valid = valid_now;
        pix_data = (fifo.size() > 0) ? fifo[0] : {$urandom, $urandom};
        ddr_s = ddr_init_done;
        fetch = act && mfen && (k == 0);
        #1;
        chk("pix_rden", pix_rden, fetch && valid_now);
        if (pix_rden === 1'b1) obs_pops++;
        if (fetch) begin
            if (valid_now) begin
                mword = fifo.pop_front();
                mok = 1'b1;
                mpops++;
            end else begin
                mok = 1'b0;
                mund = 1'b1;
            end
        end
        px = (act && mfen && mok) ? mword[63 - 16 * k -: 16] : 16'h0;
        @(posedge vga_clk);
        #1;
        chk("hsync", hs, (h < 4) ? 1'b0 : 1'b1);
        chk("vsync", vs, (v < 2) ? 1'b0 : 1'b1);
        chk("de", de, act);
        chk("rgb", {r, g, b}, act ? exp888(px) : 24'h0);
        chk("frame_start", fs, fs_e);
        chk("underflow", uf, mund);
        if (de === 1'b1) de_cnt++;
        if ({r, g, b} !== 24'h0) nz_cnt++;
        if (fs_e) mfen = ddr_s;
        t++;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hsync"}, hs, 1'b1);
        chk({tag, "_vsync"}, vs, 1'b1);
        chk({tag, "_de"}, de, 1'b0);
        chk({tag, "_rgb"}, {r, g, b}, 24'h0);
        chk({tag, "_fs"}, fs, 1'b0);
        chk({tag, "_uf"}, uf, 1'b0);
        chk({tag, "_rden"}, pix_rden, 1'b0);
    endtask

    initial begin
        int hs_low0, hs_low1, hs_rise, vs_low, dfs_cnt;
        logic hs_1663, hs_1664;

        // Reset state.
        repeat (3) @(posedge vga_clk);
        #1;
        chk_reset_vals("rst");
        fifo.delete();
        fill(1'b0);
        vga_rst_n = 1'b1;
        model_reset();

        // Two frames of the fixed pixel pattern with ddr ready from reset.
        for (int f = 0; f < 2; f++) begin
            clear_counts();
            fill(1'b0);
            repeat (FT) step();
            chk("pops_frame", obs_pops, 8);
            chk("de_per_frame", de_cnt, 32);
        end

        // FIFO empty at the first word of line 5.
        clear_counts();
        fill(1'b0);
        starve_line = 5;
        repeat (FT) step();
        starve_line = -1;
        chk("pops_starved", obs_pops, 7);
        chk("underflow_set", uf, 1'b1);
        clear_counts();
        fill(1'b0);
        repeat (FT) step();
        chk("pops_after_starve", obs_pops, 8);

        // ddr_init_done low at the frame boundary, raised mid-frame.
        clear_counts();
        fill(1'b0);
        ddr_init_done = 1'b0;
        repeat (60) step();
        ddr_init_done = 1'b1;
        repeat (FT - 60) step();
        chk("pops_disabled", obs_pops, 0);
        chk("black_frame", nz_cnt, 0);
        clear_counts();
        fill(1'b0);
        repeat (FT) step();
        chk("pops_reenabled", obs_pops, 8);

        // Random words with random FIFO stalls.
        rand_gate = 1'b1;
        for (int f = 0; f < 2; f++) begin
            clear_counts();
            fifo.delete();
            fill(1'b1);
            repeat (FT) step();
            chk("pops_random", obs_pops, mpops);
        end
        rand_gate = 1'b0;

        // Reset in the middle of an active line.
        fill(1'b0);
        repeat (5 * HT + 10) step();
        vga_rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(posedge vga_clk);
        #1;
        vga_rst_n = 1'b1;
        model_reset();
        clear_counts();
        fifo.delete();
        fill(1'b0);
        repeat (FT) step();
        chk("pops_after_reset", obs_pops, 8);

        // Default-parameter instance: full-size sync timing.
        vga_rst_n = 1'b0;
        @(posedge vga_clk);
        #1;
        vga_rst_n = 1'b1;
        hs_low0 = 0;
        hs_low1 = 0;
        hs_rise = -1;
        vs_low = 0;
        dfs_cnt = 0;
        hs_1663 = 1'bx;
        hs_1664 = 1'bx;
        for (int c = 0; c < 8 * DEF_HT; c++) begin
            @(posedge vga_clk);
            #1;
            if ((c < DEF_HT) && (d_hs === 1'b0)) hs_low0++;
            if ((c >= DEF_HT) && (c < 2 * DEF_HT) && (d_hs === 1'b0)) hs_low1++;
            if ((hs_rise < 0) && (d_hs === 1'b1)) hs_rise = c;
            if (c == DEF_HT - 1) hs_1663 = d_hs;
            if (c == DEF_HT) hs_1664 = d_hs;
            if (d_vs === 1'b0) vs_low++;
            if (d_fs === 1'b1) dfs_cnt++;
        end
        chk("def_hs_low_line0", hs_low0, 128);
        chk("def_hs_low_line1", hs_low1, 128);
        chk("def_hs_rise", hs_rise, 128);
        chk("def_hs_line_end", hs_1663, 1'b1);
        chk("def_hs_line_wrap", hs_1664, 1'b0);
        chk("def_vs_low", vs_low, 7 * DEF_HT);
        chk("def_frame_start", dfs_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
